// File: rtl/imem_pkg.sv
// imem_pkg: instruction memory geometry and loader state encoding shared by the loader files.
package imem_pkg;
    localparam int IMEM_ADDR_W = 13;
    localparam int IMEM_DATA_W = 16;
    localparam int IMEM_DEPTH = 1 << IMEM_ADDR_W;
    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} loader_state_t;
endpackage

// File: rtl/imem_wr_port.sv
// imem_wr_port: registered instruction memory write stage with address pointer and word count.
module imem_wr_port
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   words_written
);
    localparam logic [ADDR_W-1:0] BA = ADDR_W'(BASE_ADDR);
    logic [ADDR_W-1:0] ptr;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en <= 1'b0;
            wr_addr <= BA;
            wr_data <= '0;
            ptr <= BA;
            words_written <= '0;
        end else begin
            wr_en <= push;
            if (clear) begin
                ptr <= BA;
                wr_addr <= BA;
                words_written <= '0;
            end else if (push) begin
                ptr <= ptr + 1'b1;
                wr_addr <= ptr;
                wr_data <= data;
                words_written <= words_written + 1'b1;
            end
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed image into instruction memory while holding CPU fetch.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum word after the data.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t FIN = CSUM;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] total;
    assign total = sum + s_data;
`else
    localparam loader_state_t FIN = DONE;
`endif
    loader_state_t state, nxt;
    logic [DATA_W-1:0] rem;
    logic push, clear, too_long;
    assign s_ready = state inside {HDR, DATA, CSUM};
    assign push = (state == DATA) && s_valid;
    assign clear = start && (state inside {IDLE, DONE, ERR});
    // Images that would run past the top of memory are refused before any write.
    assign too_long = int'(s_data) > (1 << ADDR_W) - BASE_ADDR;
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: nxt = start ? HDR : state;
            HDR: nxt = !s_valid ? HDR : (s_data == '0) ? FIN : too_long ? ERR : DATA;
            DATA: nxt = (s_valid && rem == DATA_W'(1)) ? FIN : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: nxt = !s_valid ? CSUM : (total == '0) ? DONE : ERR;
`endif
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rem <= '0;
            busy <= 1'b0;
            cpu_hold <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= nxt;
            busy <= nxt inside {HDR, DATA, CSUM};
            // A pending write keeps fetch held for the cycle it lands.
            cpu_hold <= (nxt inside {HDR, DATA, CSUM}) || push;
            done <= nxt == DONE;
            error <= nxt == ERR;
            if (state == HDR && s_valid) rem <= s_data;
            else if (push) rem <= rem - 1'b1;
        end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || clear) sum <= '0;
        else if (push) sum <= sum + s_data;
    end
`endif
    imem_wr_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR)) u_wr (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .push(push),
        .data(s_data),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .words_written(words_written)
    );
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads with a write scoreboard checking address, data and strobe count.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic s_ready, wr_en, cpu_hold, busy, done, error;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic [13:0] words_written;
    int errors = 0;
    int checks = 0;
    int nwr = 0;
    int cyc = 0;
    int wr_cyc[$];
    logic [31:0] exp_q[$];
    logic [15:0] img[$];
    logic [12:0] exp_addr = '0;

    imem_loader #(.BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            logic [31:0] e;
            nwr++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("spurious_wr", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[28:16]));
                check("wr_data", 32'(wr_data), 32'(e[15:0]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = '0;
    endtask

    task automatic send(input logic [15:0] w, input bit is_data);
        int n = 0;
        s_valid = 1'b1;
        s_data = w;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        check("s_ready_wait", 32'(s_ready), 32'd1);
        if (is_data) begin
            exp_q.push_back({3'b0, exp_addr, w});
            exp_addr++;
        end
        tick();
    endtask

    task automatic load(input bit bubble);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [15:0] sum = '0;
`endif
        send(16'(img.size()), 1'b0);
        foreach (img[i]) begin
            send(img[i], 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum += img[i];
`endif
            if (bubble) begin
                s_valid = 1'b0;
                tick();
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(16'd0 - sum, 1'b0);
`endif
        s_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_words"}, 32'(words_written), 32'd0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check_reset("rst");
        // three words, continuous valid
        do_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_ready", 32'(s_ready), 32'd1);
        img.delete();
        img.push_back(16'h1111);
        img.push_back(16'h2222);
        img.push_back(16'h3333);
        wr_cyc.delete();
        n0 = nwr;
        load(1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("t1_hold_last_wr", 32'(cpu_hold), 32'd1);
        check("t1_wr_en_last", 32'(wr_en), 32'd1);
`endif
        tick();
        check("t1_hold_drop", 32'(cpu_hold), 32'd0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_words", 32'(words_written), 32'd3);
        check("t1_nwr", 32'(nwr - n0), 32'd3);
        check("t1_consecutive", 32'(wr_cyc[2] - wr_cyc[0]), 32'd2);
        // four words with bubbles
        do_start();
        check("t2_done_cleared", 32'(done), 32'd0);
        img.delete();
        for (int i = 0; i < 4; i++) img.push_back(16'hA000 + 16'(i));
        n0 = nwr;
        load(1'b1);
        repeat (2) tick();
        check("t2_nwr", 32'(nwr - n0), 32'd4);
        check("t2_words", 32'(words_written), 32'd4);
        check("t2_done", 32'(done), 32'd1);
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);
        // oversize length
        do_start();
        n0 = nwr;
        send(16'h2001, 1'b0);
        s_valid = 1'b0;
        check("t3_error", 32'(error), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_hold", 32'(cpu_hold), 32'd0);
        check("t3_done", 32'(done), 32'd0);
        check("t3_ready", 32'(s_ready), 32'd0);
        repeat (3) tick();
        check("t3_nwr", 32'(nwr - n0), 32'd0);
        do_start();
        check("t3_error_cleared", 32'(error), 32'd0);
        img.delete();
        img.push_back(16'hBEEF);
        load(1'b0);
        repeat (2) tick();
        check("t3b_done", 32'(done), 32'd1);
        check("t3b_words", 32'(words_written), 32'd1);
        // full-depth image reaches the last address
        do_start();
        img.delete();
        for (int i = 0; i < 8192; i++) img.push_back(16'(i) ^ 16'h5A5A);
        n0 = nwr;
        load(1'b0);
        repeat (2) tick();
        check("t_full_done", 32'(done), 32'd1);
        check("t_full_error", 32'(error), 32'd0);
        check("t_full_words", 32'(words_written), 32'd8192);
        check("t_full_nwr", 32'(nwr - n0), 32'd8192);
        // reset mid-load
        do_start();
        n0 = nwr;
        send(16'd5, 1'b0);
        send(16'hC001, 1'b1);
        send(16'hC002, 1'b1);
        s_valid = 1'b0;
        reset = 1'b1;
        tick();
        check_reset("t4");
        reset = 1'b0;
        s_valid = 1'b1;
        s_data = 16'hC003;
        repeat (3) tick();
        s_valid = 1'b0;
        check("t4_nwr", 32'(nwr - n0), 32'd2);
        check("t4_q_empty", 32'(exp_q.size()), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        do_start();
        send(16'd2, 1'b0);
        send(16'h0001, 1'b1);
        send(16'h0002, 1'b1);
        send(16'hFFFD, 1'b0);
        s_valid = 1'b0;
        tick();
        check("t5_good_done", 32'(done), 32'd1);
        check("t5_good_error", 32'(error), 32'd0);
        do_start();
        n0 = nwr;
        send(16'd2, 1'b0);
        send(16'h0001, 1'b1);
        send(16'h0002, 1'b1);
        send(16'h0000, 1'b0);
        s_valid = 1'b0;
        tick();
        check("t5_bad_error", 32'(error), 32'd1);
        check("t5_bad_done", 32'(done), 32'd0);
        check("t5_bad_nwr", 32'(nwr - n0), 32'd2);
`endif
        // start during DATA is ignored
        do_start();
        n0 = nwr;
        send(16'd3, 1'b0);
        send(16'hD001, 1'b1);
        start = 1'b1;
        send(16'hD002, 1'b1);
        start = 1'b0;
        send(16'hD003, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(16'd0 - 16'hD001 - 16'hD002 - 16'hD003, 1'b0);
`endif
        s_valid = 1'b0;
        repeat (2) tick();
        check("t6_done", 32'(done), 32'd1);
        check("t6_words", 32'(words_written), 32'd3);
        check("t6_nwr", 32'(nwr - n0), 32'd3);
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
